// File: rtl/ad9273_spi_pkg.sv
// Shared constants and types for the AD9273 SPI arbiter.
package ad9273_spi_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [ADDR_W-1:0] REG_DEV_INDEX2    = 13'h004;
  localparam logic [ADDR_W-1:0] REG_DEV_INDEX1    = 13'h005;
  localparam logic [ADDR_W-1:0] REG_DEVICE_UPDATE = 13'h0FF;
  localparam logic [DATA_W-1:0] UPDATE_EN         = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_OVER,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/ad9273_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ad9273_spi_arbiter.sv
// Round-robin, transaction-locked sharing of one SPI_AD engine between NUM_REQ requesters,
// with a watchdog on the engine's Over handshake.
module ad9273_spi_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       SPI_CLK,
  input  logic                       RST_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [IW-1:0]              owner,
  output logic                       eng_new_word,
  output logic [ADDR_W-1:0]          eng_addr,
  output logic [DATA_W-1:0]          eng_data,
  output logic                       eng_rw,
  input  logic [DATA_W-1:0]          eng_q,
  input  logic                       eng_over
);
  import ad9273_spi_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e        state_reg;
  logic              lock_reg;
  logic              last_reg;
  logic [IW-1:0]     rr_ptr_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // While locked, only the owner is offered to the picker, so one path serves both cases.
  logic [NUM_REQ-1:0] owner_mask, pick_req, pick_grant;
  logic [IW-1:0]      pick_ptr, pick_idx, ptr_next;
  logic               pick_any;

  assign owner_mask = NUM_REQ'(1) << owner;
  assign pick_req   = lock_reg ? (req_valid & owner_mask) : req_valid;
  assign pick_ptr   = lock_reg ? owner : rr_ptr_reg;
  assign ptr_next   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy       = (state_reg != ST_IDLE) || lock_reg;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_rw, sel_last;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = addr_arr[i];
        sel_data = data_arr[i];
        sel_rw   = req_rw[i];
        sel_last = req_last[i];
      end
    end
  end

  always_ff @(posedge SPI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg    <= ST_IDLE;
      lock_reg     <= 1'b0;
      last_reg     <= 1'b0;
      rr_ptr_reg   <= '0;
      tmo_cnt_reg  <= '0;
      owner        <= '0;
      req_done     <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      timeout_err  <= 1'b0;
      eng_new_word <= 1'b0;
      eng_addr     <= '0;
      eng_data     <= '0;
      eng_rw       <= 1'b0;
    end else begin
      eng_new_word <= 1'b0;
      req_done     <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            eng_addr     <= sel_addr;
            eng_data     <= sel_data;
            eng_rw       <= sel_rw;
            last_reg     <= sel_last;
            owner        <= pick_idx;
            lock_reg     <= 1'b1;
            eng_new_word <= 1'b1;
            state_reg    <= ST_ISSUE;
          end else begin
            lock_reg <= 1'b0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt_reg <= '0;
          state_reg   <= ST_WAIT_BUSY;
        end
        // Over may still be high from the previous word; wait to see it low first.
        ST_WAIT_BUSY: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (!eng_over) begin
            state_reg <= ST_WAIT_OVER;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
            req_done    <= owner_mask;
            state_reg   <= ST_DONE;
          end
        end
        ST_WAIT_OVER: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (eng_over) begin
            rsp_data  <= eng_q;
            rsp_err   <= 1'b0;
            req_done  <= owner_mask;
            state_reg <= ST_DONE;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
            req_done    <= owner_mask;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_err <= 1'b0;
          if (last_reg || rsp_err) begin
            lock_reg   <= 1'b0;
            rr_ptr_reg <= ptr_next;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9273_spi_arbiter.sv
// Self-checking bench: SPI_AD engine model plus a transaction-level round-robin reference.
module tb_ad9273_spi_arbiter;
  import ad9273_spi_pkg::*;

  localparam int NR  = 3;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int TMO = 64;
  localparam logic [AW-1:0] HANG_ADDR = 13'h1ABC;

  logic SPI_CLK = 1'b0;
  logic RST_n   = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_last = '0, req_rw = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_done;
  logic [DW-1:0]    rsp_data, eng_data, eng_q;
  logic             rsp_err, timeout_err, busy, eng_new_word, eng_rw, eng_over;
  logic [1:0]       owner;
  logic [AW-1:0]    eng_addr;

  always #5 SPI_CLK = ~SPI_CLK;

  ad9273_spi_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .SPI_CLK(SPI_CLK), .RST_n(RST_n), .req_valid(req_valid), .req_last(req_last),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .req_done(req_done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .timeout_err(timeout_err), .busy(busy),
    .owner(owner), .eng_new_word(eng_new_word), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_rw(eng_rw), .eng_q(eng_q), .eng_over(eng_over)
  );

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    if (a == 13'h001) return 8'h2F;
    return a[7:0] ^ 8'hA5;
  endfunction

  // Engine model: Over low 2 cycles after New_Word, high again 34 cycles later; HANG_ADDR never ends.
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_rw, e_act;
  int            e_cnt;
  logic [7:0]    e_mem [8192];
  bit            e_valid [8192];

  always @(posedge SPI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      e_act    <= 1'b0;
      e_cnt    <= 0;
      eng_over <= 1'b1;
      e_addr   <= '0;
      e_data   <= '0;
      e_rw     <= 1'b0;
    end else if (eng_new_word) begin
      e_act  <= 1'b1;
      e_cnt  <= 0;
      e_addr <= eng_addr;
      e_data <= eng_data;
      e_rw   <= eng_rw;
    end else if (e_act) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt == 1) eng_over <= 1'b0;
      if (e_cnt == 35 && e_addr != HANG_ADDR) begin
        eng_over <= 1'b1;
        e_act    <= 1'b0;
        if (e_rw) begin
          e_mem[e_addr]   <= e_data;
          e_valid[e_addr] <= 1'b1;
        end
      end
    end
  end

  assign eng_q = e_rw ? 8'h00 : (e_valid[e_addr] ? e_mem[e_addr] : init_val(e_addr));

  typedef struct {
    int            req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
    logic          last;
  } word_t;

  word_t      warr [NR][16];
  int         wcnt [NR];
  int         whead [NR];
  bit         pop_pend [NR];
  word_t      exp_seq [$];
  int         model_ptr = 0;
  logic [7:0] x_mem [8192];
  bit         x_valid [8192];
  int         checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      wcnt[i] = 0; whead[i] = 0; pop_pend[i] = 0;
    end
  endtask

  task automatic add_word(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic rw, input logic last);
    warr[r][wcnt[r]] = '{r, a, d, rw, last};
    wcnt[r]++;
  endtask

  task automatic drive_reqs();
    word_t w;
    for (int i = 0; i < NR; i++) begin
      if (pop_pend[i]) begin whead[i]++; pop_pend[i] = 0; end
      if (whead[i] < wcnt[i]) begin
        w = warr[i][whead[i]];
        req_valid[i] = 1'b1;
        req_last[i]  = w.last;
        req_rw[i]    = w.rw;
        req_addr[i*AW +: AW] = w.addr;
        req_data[i*DW +: DW] = w.data;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge SPI_CLK); #1;
    cyc++;
    drive_reqs();
  endtask

  // Reference: whole transactions in round-robin order; a timed-out word ends its transaction.
  task automatic build_expected();
    int h [NR];
    int sel, i;
    word_t w;
    exp_seq.delete();
    for (int k = 0; k < NR; k++) h[k] = whead[k];
    while (1) begin
      sel = -1;
      for (int k = 0; k < NR; k++) begin
        i = (model_ptr + k) % NR;
        if (sel < 0 && h[i] < wcnt[i]) sel = i;
      end
      if (sel < 0) break;
      do begin
        w = warr[sel][h[sel]];
        h[sel]++;
        exp_seq.push_back(w);
      end while (!w.last && w.addr != HANG_ADDR && h[sel] < wcnt[sel]);
      model_ptr = (sel + 1) % NR;
    end
  endtask

  task automatic run_phase(input string name);
    int issue_idx = 0, done_idx = 0, t_issue = 0, start = cyc, lat;
    word_t w;
    logic [7:0] xr;
    build_expected();
    while (done_idx < exp_seq.size() && cyc - start < 3000) begin
      step();
      if (eng_new_word) begin
        if (issue_idx == 0) chk({name, " grant_latency"}, cyc - start, 2);
        if (issue_idx < exp_seq.size()) begin
          w = exp_seq[issue_idx];
          chk({name, " eng_addr"}, eng_addr, w.addr);
          chk({name, " eng_data"}, eng_data, w.data);
          chk({name, " eng_rw"}, eng_rw, w.rw);
        end else begin
          chk({name, " extra_issue"}, eng_new_word, 0);
        end
        issue_idx++;
        t_issue = cyc;
      end
      if (req_done != '0) begin
        w   = exp_seq[done_idx];
        lat = cyc - t_issue;
        chk({name, " req_done"}, req_done, 32'(1) << w.req);
        chk({name, " owner"}, owner, w.req);
        chk({name, " rsp_err"}, rsp_err, w.addr == HANG_ADDR);
        if (w.addr == HANG_ADDR) begin
          chk({name, " tmo_data"}, rsp_data, 0);
          chk({name, " tmo_latency"}, lat >= TMO && lat <= TMO + 2, 1);
        end else begin
          chk({name, " latency"}, lat >= 30 && lat <= 45, 1);
          if (w.rw == RW_WRITE) begin
            x_mem[w.addr] = w.data; x_valid[w.addr] = 1'b1;
          end else begin
            xr = x_valid[w.addr] ? x_mem[w.addr] : init_val(w.addr);
            chk({name, " rsp_data"}, rsp_data, xr);
          end
        end
        pop_pend[w.req] = 1;
        done_idx++;
      end
      $display("%s cyc=%0d issued=%0d done=%0d", name, cyc, issue_idx, done_idx);
    end
    chk({name, " complete"}, done_idx, exp_seq.size());
    repeat (3) step();
    chk({name, " idle_busy"}, busy, 0);
    chk({name, " idle_done"}, req_done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_a"}, {req_done, rsp_data, rsp_err, timeout_err, busy, owner, eng_new_word}, 0);
    chk({tag, " out_b"}, {eng_addr, eng_data, eng_rw}, 0);
  endtask

  initial begin
    int k;
    clear_reqs();
    drive_reqs();
    repeat (3) @(posedge SPI_CLK);
    #1;
    chk_all_zero("reset");
    RST_n = 1'b1;
    repeat (2) step();

    clear_reqs();
    add_word(0, 13'h011, 8'h0E, RW_WRITE, 1'b1);
    run_phase("single_write");

    clear_reqs();
    for (int r = 0; r < NR; r++) begin
      add_word(r, AW'(13'h020 + r), 8'(8'h40 + r), RW_WRITE, 1'b1);
      add_word(r, AW'(13'h030 + r), 8'(8'h50 + r), RW_WRITE, 1'b1);
    end
    run_phase("contention");

    clear_reqs();
    add_word(0, 13'h040, 8'h11, RW_WRITE, 1'b1);
    add_word(1, REG_DEV_INDEX2, 8'h0F, RW_WRITE, 1'b0);
    add_word(1, 13'h016, 8'h03, RW_WRITE, 1'b0);
    add_word(1, REG_DEVICE_UPDATE, UPDATE_EN, RW_WRITE, 1'b1);
    add_word(2, 13'h041, 8'h22, RW_WRITE, 1'b1);
    run_phase("lock");

    clear_reqs();
    add_word(2, 13'h001, 8'h00, RW_READ, 1'b1);
    run_phase("read");

    clear_reqs();
    add_word(0, HANG_ADDR, 8'h77, RW_WRITE, 1'b0);
    add_word(0, 13'h050, 8'h33, RW_WRITE, 1'b1);
    add_word(1, 13'h051, 8'h44, RW_WRITE, 1'b1);
    run_phase("timeout");
    chk("timeout_err_set", timeout_err, 1);

    for (int rnd = 0; rnd < 5; rnd++) begin
      clear_reqs();
      for (int r = 0; r < NR; r++) begin
        for (int t = $urandom_range(0, 2); t > 0; t--) begin
          int nw;
          nw = $urandom_range(1, 3);
          for (int j = 0; j < nw; j++)
            add_word(r, AW'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)),
                     j == nw - 1);
        end
      end
      run_phase("random");
    end
    chk("timeout_err_sticky", timeout_err, 1);

    clear_reqs();
    add_word(0, 13'h00A, 8'h99, RW_WRITE, 1'b1);
    k = 0;
    while (!eng_new_word && k < 20) begin step(); k++; end
    chk("rst_issue", eng_new_word, 1);
    repeat (10) step();
    chk("rst_mid_busy", busy, 1);
    #2 RST_n = 1'b0;
    clear_reqs();
    drive_reqs();
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge SPI_CLK);
    #3 RST_n = 1'b1;
    model_ptr = 0;
    clear_reqs();
    add_word(2, 13'h060, 8'h5C, RW_WRITE, 1'b1);
    add_word(1, 13'h00A, 8'h00, RW_READ, 1'b1);
    run_phase("post_reset");
    chk("post_reset_tmo_err", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
